// File: rtl/threshold_pkg.sv
`default_nettype none
// ============================================================================
// Module      : threshold_pkg
// Description : Shared definitions for the multi-channel threshold detector:
//               default datapath widths and the per-channel FSM state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package threshold_pkg;

    // Default widths: sample/threshold bits, channel count, run counter bits
    localparam int c_IL_DEFAULT  = 10;
    localparam int c_NCH_DEFAULT = 4;
    localparam int c_CW_DEFAULT  = 4;

    // Per-channel FSM state encoding
    localparam int         c_STATE_W   = 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ARMING = 2'd1;
    localparam logic [1:0] c_ST_ACTIVE = 2'd2;

endpackage : threshold_pkg
`default_nettype wire

// File: rtl/threshold_channel.sv
`default_nettype none
// ============================================================================
// Module      : threshold_channel
// Description : One detector channel. A sample must meet the raise threshold
//               for a programmable number of consecutive accepted samples
//               before the channel goes ACTIVE; it leaves ACTIVE on the
//               release condition (single threshold or hysteresis).
// Ports       : clk        - clock, rising edge
//               rstN       - asynchronous active-low reset
//               i_en       - sample-valid strobe
//               i_sample   - unsigned sample for this channel
//               i_thHi     - raise threshold
//               i_thLo     - release threshold (hysteresis mode)
//               i_mode     - 0 single threshold, 1 hysteresis
//               i_persist  - required run length (0 behaves as 1)
//               o_active   - channel is in ACTIVE
//               o_rise     - one-cycle pulse on entry to ACTIVE
// Revision    : 1.0 - initial release
// ============================================================================
module threshold_channel
    import threshold_pkg::*;
#(
    parameter int IL = c_IL_DEFAULT,
    parameter int CW = c_CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          i_en,
    input  logic [IL-1:0] i_sample,
    input  logic [IL-1:0] i_thHi,
    input  logic [IL-1:0] i_thLo,
    input  logic          i_mode,
    input  logic [CW-1:0] i_persist,
    output logic          o_active,
    output logic          o_rise
);

    localparam logic [CW-1:0] c_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [c_STATE_W-1:0] r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_rise;

    logic                 w_raise;
    logic                 w_release;
    logic [CW-1:0]        w_effPersist;
    logic [CW-1:0]        w_cntSat;
    logic [CW:0]          w_cntInc;
    logic                 w_reached;

    assign w_raise      = (i_sample >= i_thHi);
    assign w_release    = i_mode ? (i_sample < i_thLo) : (i_sample < i_thHi);
    assign w_effPersist = (i_persist == '0) ? c_ONE : i_persist;

    // The comparison uses a one-bit-wider increment so it is exact even when
    // the stored count has saturated; the stored count itself never wraps.
    assign w_cntInc  = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
    assign w_reached = (w_cntInc >= {1'b0, w_effPersist});
    assign w_cntSat  = (r_cnt == {CW{1'b1}}) ? r_cnt : w_cntInc[CW-1:0];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (i_en) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_raise) begin
                            r_cnt <= c_ONE;
                            if (w_effPersist == c_ONE) begin
                                r_state <= c_ST_ACTIVE;
                                r_rise  <= 1'b1;
                            end else begin
                                r_state <= c_ST_ARMING;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    c_ST_ARMING: begin
                        if (w_raise) begin
                            r_cnt <= w_cntSat;
                            if (w_reached) begin
                                r_state <= c_ST_ACTIVE;
                                r_rise  <= 1'b1;
                            end
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    c_ST_ACTIVE: begin
                        if (w_release) begin
                            r_state <= c_ST_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_active = (r_state == c_ST_ACTIVE);
    assign o_rise   = r_rise;

endmodule : threshold_channel
`default_nettype wire

// File: rtl/threshold_detector.sv
`default_nettype none
// ============================================================================
// Module      : threshold_detector
// Description : NCH independent persistence-qualified threshold detectors
//               sharing thresholds, mode and persistence settings.
// Ports       : iCLK     - clock, rising edge
//               iRSTn    - asynchronous active-low reset
//               iEN      - sample-valid strobe
//               iDATA    - NCH packed unsigned samples, channel k at [k*IL +: IL]
//               iTH_HI   - raise threshold
//               iTH_LO   - release threshold (hysteresis mode)
//               iMODE    - 0 single threshold, 1 hysteresis
//               iPERSIST - consecutive qualifying samples to assert
//               oDATA    - per-channel detection flags
//               oEN      - iEN delayed one cycle
//               oRISE    - per-channel entry-to-ACTIVE pulses
//               oANY     - OR of oDATA
// Revision    : 1.0 - initial release
// ============================================================================
module threshold_detector
    import threshold_pkg::*;
#(
    parameter int IL  = c_IL_DEFAULT,
    parameter int NCH = c_NCH_DEFAULT,
    parameter int CW  = c_CW_DEFAULT
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iEN,
    input  logic [NCH*IL-1:0] iDATA,
    input  logic [IL-1:0]     iTH_HI,
    input  logic [IL-1:0]     iTH_LO,
    input  logic              iMODE,
    input  logic [CW-1:0]     iPERSIST,
    output logic [NCH-1:0]    oDATA,
    output logic              oEN,
    output logic [NCH-1:0]    oRISE,
    output logic              oANY
);

    logic r_en;

    for (genvar k = 0; k < NCH; k++) begin : g_channel
        threshold_channel #(
            .IL (IL),
            .CW (CW)
        ) u_channel (
            .clk       (iCLK),
            .rstN      (iRSTn),
            .i_en      (iEN),
            .i_sample  (iDATA[k*IL +: IL]),
            .i_thHi    (iTH_HI),
            .i_thLo    (iTH_LO),
            .i_mode    (iMODE),
            .i_persist (iPERSIST),
            .o_active  (oDATA[k]),
            .o_rise    (oRISE[k])
        );
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_en <= 1'b0;
        end else begin
            r_en <= iEN;
        end
    end

    assign oEN  = r_en;
    assign oANY = |oDATA;

endmodule : threshold_detector
`default_nettype wire

// File: tb/tb_threshold_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_threshold_detector
// Description : Directed self-checking bench for threshold_detector with
//               default parameters (IL=10, NCH=4, CW=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_threshold_detector;

    localparam int IL  = 10;
    localparam int NCH = 4;
    localparam int CW  = 4;

    logic              r_clk;
    logic              r_rstN;
    logic              r_en;
    logic [NCH*IL-1:0] r_data;
    logic [IL-1:0]     r_thHi;
    logic [IL-1:0]     r_thLo;
    logic              r_mode;
    logic [CW-1:0]     r_persist;
    logic [NCH-1:0]    w_oData;
    logic              w_oEn;
    logic [NCH-1:0]    w_oRise;
    logic              w_oAny;

    int nAsserts;
    int nFails;

    threshold_detector #(
        .IL  (IL),
        .NCH (NCH),
        .CW  (CW)
    ) u_dut (
        .iCLK     (r_clk),
        .iRSTn    (r_rstN),
        .iEN      (r_en),
        .iDATA    (r_data),
        .iTH_HI   (r_thHi),
        .iTH_LO   (r_thLo),
        .iMODE    (r_mode),
        .iPERSIST (r_persist),
        .oDATA    (w_oData),
        .oEN      (w_oEn),
        .oRISE    (w_oRise),
        .oANY     (w_oAny)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one sample set, clock it in, and settle 1 time unit after the edge
    task automatic step(input logic en, input int d0, input int d1, input int d2, input int d3);
        r_en   = en;
        r_data = {IL'(d3), IL'(d2), IL'(d1), IL'(d0)};
        @(posedge r_clk);
        #1;
    endtask

    task automatic checkOut(input string tag, input logic [3:0] expData,
                            input logic [3:0] expRise, input logic expEn);
        check({tag, ".data"}, 32'(w_oData), 32'(expData));
        check({tag, ".rise"}, 32'(w_oRise), 32'(expRise));
        check({tag, ".en"},   32'(w_oEn),   32'(expEn));
        check({tag, ".any"},  32'(w_oAny),  32'(expData != 4'b0000));
    endtask

    initial begin
        nAsserts  = 0;
        nFails    = 0;
        r_rstN    = 1'b0;
        r_en      = 1'b0;
        r_data    = '0;
        r_thHi    = 10'd100;
        r_thLo    = 10'd50;
        r_mode    = 1'b0;
        r_persist = 4'd1;
        #1;
        checkOut("reset", 4'b0000, 4'b0000, 1'b0);
        @(posedge r_clk);
        @(posedge r_clk);
        #1;
        r_rstN = 1'b1;

        // Single threshold, persist 1, channel 0: 99, 100, 99
        step(1'b1, 99, 0, 0, 0);   checkOut("st_99a",  4'b0000, 4'b0000, 1'b1);
        step(1'b1, 100, 0, 0, 0);  checkOut("st_100",  4'b0001, 4'b0001, 1'b1);
        step(1'b1, 99, 0, 0, 0);   checkOut("st_99b",  4'b0000, 4'b0000, 1'b1);
        step(1'b0, 0, 0, 0, 0);    checkOut("st_idle", 4'b0000, 4'b0000, 1'b0);

        // Hysteresis, channel 1: 120, 80, 60, 49
        r_mode = 1'b1;
        step(1'b1, 0, 120, 0, 0);  checkOut("hy_120", 4'b0010, 4'b0010, 1'b1);
        step(1'b1, 0, 80, 0, 0);   checkOut("hy_80",  4'b0010, 4'b0000, 1'b1);
        step(1'b1, 0, 60, 0, 0);   checkOut("hy_60",  4'b0010, 4'b0000, 1'b1);
        step(1'b1, 0, 49, 0, 0);   checkOut("hy_49",  4'b0000, 4'b0000, 1'b1);

        // Persist 3, channel 2: 200,200,10,200,200,200
        r_mode    = 1'b0;
        r_persist = 4'd3;
        step(1'b1, 0, 0, 200, 0);  checkOut("p3_s1", 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 0, 0, 200, 0);  checkOut("p3_s2", 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 0, 0, 10, 0);   checkOut("p3_s3", 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 0, 0, 200, 0);  checkOut("p3_s4", 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 0, 0, 200, 0);  checkOut("p3_s5", 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 0, 0, 200, 0);  checkOut("p3_s6", 4'b0100, 4'b0100, 1'b1);
        step(1'b1, 0, 0, 0, 0);    checkOut("p3_rel", 4'b0000, 4'b0000, 1'b1);

        // Persist 3, channel 3 with a 5-cycle iEN gap after the first raise
        step(1'b1, 0, 0, 0, 200);  checkOut("gap_s1", 4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 0, 0, 0, 200);
            checkOut("gap_hold", 4'b0000, 4'b0000, 1'b0);
        end
        step(1'b1, 0, 0, 0, 200);  checkOut("gap_s2", 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 0, 0, 0, 200);  checkOut("gap_s3", 4'b1000, 4'b1000, 1'b1);
        // ACTIVE holds while iEN=0 even though the sample would release
        step(1'b0, 0, 0, 0, 0);    checkOut("act_hold", 4'b1000, 4'b0000, 1'b0);
        step(1'b1, 0, 0, 0, 0);    checkOut("act_rel",  4'b0000, 4'b0000, 1'b1);

        // iPERSIST=0 behaves as 1
        r_persist = 4'd0;
        step(1'b1, 0, 150, 0, 0);  checkOut("p0_raise", 4'b0010, 4'b0010, 1'b1);
        step(1'b1, 0, 0, 0, 0);    checkOut("p0_rel",   4'b0000, 4'b0000, 1'b1);

        // Persist 15 run, then lowered below the running count
        r_persist = 4'd15;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 0, 200, 0, 0);
            checkOut("p15_run", 4'b0000, 4'b0000, 1'b1);
        end
        r_persist = 4'd3;
        step(1'b1, 0, 200, 0, 0);  checkOut("p_lower", 4'b0010, 4'b0010, 1'b1);
        step(1'b1, 0, 0, 0, 0);    checkOut("p_lower_rel", 4'b0000, 4'b0000, 1'b1);

        // Full 15-sample run at the maximum persistence
        r_persist = 4'd15;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 0, 200, 0, 0);
        end
        checkOut("p15_14", 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 0, 200, 0, 0);  checkOut("p15_15", 4'b0010, 4'b0010, 1'b1);
        step(1'b1, 0, 0, 0, 0);    checkOut("p15_rel", 4'b0000, 4'b0000, 1'b1);

        // Mid-run reset: ch3 ACTIVE, ch0 at count 2 of 3
        r_persist = 4'd1;
        step(1'b1, 0, 0, 0, 200);  checkOut("rs_ch3", 4'b1000, 4'b1000, 1'b1);
        r_persist = 4'd3;
        step(1'b1, 200, 0, 0, 200); checkOut("rs_c1", 4'b1000, 4'b0000, 1'b1);
        step(1'b1, 200, 0, 0, 200); checkOut("rs_c2", 4'b1000, 4'b0000, 1'b1);
        r_rstN = 1'b0;
        #1;
        checkOut("rs_async", 4'b0000, 4'b0000, 1'b0);
        #1;
        r_rstN = 1'b1;
        step(1'b1, 200, 0, 0, 0);  checkOut("rs_f1", 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 200, 0, 0, 0);  checkOut("rs_f2", 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 200, 0, 0, 0);  checkOut("rs_f3", 4'b0001, 4'b0001, 1'b1);

        // All channels assert together, then only ch0 releases
        r_persist = 4'd1;
        step(1'b1, 200, 200, 200, 200); checkOut("all_on", 4'b1111, 4'b1110, 1'b1);
        step(1'b1, 0, 200, 200, 200);   checkOut("ch0_off", 4'b1110, 4'b0000, 1'b1);

        // Hysteresis with iTH_LO above iTH_HI: 120 raises, then 120 releases
        r_mode = 1'b1;
        r_thLo = 10'd150;
        step(1'b1, 120, 0, 0, 0);  checkOut("inv_raise", 4'b0001, 4'b0001, 1'b1);
        step(1'b1, 120, 0, 0, 0);  checkOut("inv_rel",   4'b0000, 4'b0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule : tb_threshold_detector
`default_nettype wire

// File: doc/threshold_detector.md
THRESHOLD_DETECTOR -- requirements
Module: threshold_detector

Interface
REQ-001 Parameter IL, default 10, sample and threshold width in bits.
REQ-002 Parameter NCH, default 4, number of independent channels.
REQ-003 Parameter CW, default 4, persistence counter width in bits.
REQ-004 iCLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 iRSTn  input  1  asynchronous, active-low reset.
REQ-006 iEN  input  1  sample-valid strobe; one accepted sample set per cycle in which iEN=1.
REQ-007 iDATA  input  NCH*IL  unsigned samples; channel k occupies bits [k*IL+IL-1 : k*IL].
REQ-008 iTH_HI  input  IL  unsigned raise threshold, shared by all channels.
REQ-009 iTH_LO  input  IL  unsigned release threshold, used only in hysteresis mode.
REQ-010 iMODE  input  1  0 = single threshold, 1 = hysteresis.
REQ-011 iPERSIST  input  CW  consecutive qualifying samples required to assert; 0 SHALL be treated as 1.
REQ-012 oDATA  output  NCH  per-channel detection flag.
REQ-013 oEN  output  1  iEN delayed by one cycle.
REQ-014 oRISE  output  NCH  one-cycle pulse per channel on entry to ACTIVE.
REQ-015 oANY  output  1  OR-reduction of oDATA.

Function
REQ-016 Each channel SHALL run an independent FSM with states IDLE, ARMING, ACTIVE and a CW-bit run counter.
REQ-017 Raise condition: sample >= iTH_HI (unsigned); release condition: sample < iTH_HI when iMODE=0, sample < iTH_LO when iMODE=1.
REQ-018 IDLE, accepted raise: to ACTIVE if effective persist = 1, else to ARMING with counter = 1; no raise: stay, counter = 0.
REQ-019 ARMING, accepted raise: counter+1; to ACTIVE when counter+1 >= effective persist; no raise: to IDLE, counter = 0.
REQ-020 ACTIVE, accepted release: to IDLE, counter = 0; otherwise stay.
REQ-021 Counter SHALL saturate at 2^CW-1 and never wrap.
REQ-022 With iEN=0, FSM state, counters, oDATA SHALL hold; oRISE SHALL be 0.
REQ-023 oDATA[k] SHALL be 1 exactly when channel k is in ACTIVE, visible the cycle after the deciding sample (latency 1), aligned with oEN.
REQ-024 oRISE[k] SHALL be 1 for the single cycle following an accepted sample that moved channel k into ACTIVE.
REQ-025 oANY SHALL be derived combinationally from registered oDATA, same cycle.
REQ-026 iMODE, thresholds and iPERSIST changes SHALL take effect on the next accepted sample without resetting any state.
REQ-027 iTH_LO > iTH_HI in hysteresis mode SHALL follow REQ-017 literally; no error handling.
REQ-028 iPERSIST reduced below a running count SHALL cause ACTIVE on the next accepted raise.

Reset
REQ-029 iRSTn=0 SHALL immediately force all FSMs to IDLE, counters to 0, and oDATA, oEN, oRISE, oANY to 0.
REQ-030 Reset asserted mid-run SHALL discard all partial persistence counts; the first cycle after release SHALL accept samples normally.

Structure
REQ-031 FSM state encoding and default IL/NCH/CW values SHALL reside in shared package threshold_pkg.
REQ-032 Per-channel FSM, counter and oRISE logic SHALL be sub-module threshold_channel, instantiated NCH times via generate; top holds oEN register and oANY.

Verification
REQ-033 iMODE=0, iTH_HI=100, iPERSIST=1, ch0 samples 99,100,99 with iEN=1 -> oDATA[0] 0,1,0 one cycle later; oRISE[0] pulses once.
REQ-034 iMODE=1, iTH_HI=100, iTH_LO=50, ch1 samples 120,80,60,49 -> oDATA[1] 1,1,1,0.
REQ-035 iPERSIST=3, ch2 samples 200,200,10,200,200,200 (iTH_HI=100) -> oDATA[2] asserts only after sixth sample.
REQ-036 iPERSIST=3, ch3 samples 200,200 with iEN gap of 5 cycles between -> counts hold across gap; third 200 asserts oDATA[3].
REQ-037 iRSTn pulsed low while ch0 in ARMING (count 2 of 3) -> all outputs 0 at once; after release, three fresh raises needed.
REQ-038 All four channels asserted simultaneously, then ch0 only released -> oANY stays 1, oDATA = 4'b1110.
